game_countdown: RTL and testbench
=================================

# game_countdown

Countdown round timer that consumes the one-cycle 1 s tick pulse from the design's tick generator and turns it into the game's remaining-time state. It runs from a programmable start value down to zero and supports pause, restart and saturating time bonuses. It drives two BCD digits for the seven-segment/VGA score area, plus status flags for the game FSM.

## Interface
- `START_SEC`, default 60: seconds loaded on `start`; legal range 1..99.
- `BONUS_SEC`, default 5: seconds added per `bonus` pulse; legal range 1..99.
- `WARN_SEC`, default 10: `warn` is high while running/paused with remaining ≤ this value.
- `clk`, in, 1: system clock, 100 MHz.
- `rst`, in, 1: reset, synchronous and active-high.
- `tick_1s`, in, 1: one-cycle pulse, nominally once per 100 000 000 cycles.
- `start`, in, 1: one-cycle pulse; loads `START_SEC` and enters RUN.
- `pause`, in, 1: level; while high in RUN/PAUSE, ticks are ignored.
- `bonus`, in, 1: one-cycle pulse; adds `BONUS_SEC`, saturating at 99.
- `sec_tens`, out, 4: BCD tens digit of remaining seconds.
- `sec_ones`, out, 4: BCD ones digit of remaining seconds.
- `running`, out, 1: high in RUN.
- `paused`, out, 1: high in PAUSE.
- `warn`, out, 1: low-time indication.
- `done`, out, 1: level; high in DONE.
- `timeout`, out, 1: one-cycle pulse on entry to DONE.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Remaining time is held as a 7-bit binary count `rem` (0..99). The digits are derived from it.
- IDLE:
  - `rem` = 0.
  - `start` → RUN with `rem` = `START_SEC`.
  - `tick_1s`, `pause` and `bonus` are ignored.
- RUN:
  - `pause`=1 → PAUSE. This takes effect the same cycle: a tick coinccident with pause=1 is dropped.
  - Tick with `rem` > 1 → `rem` − 1.
  - Tick with `rem` = 1 → `rem` = 0, DONE, and `timeout` pulses.
- PAUSE:
  - `pause`=0 → RUN.
  - `bonus` is still accepted.
  - `start` restarts into RUN with `START_SEC`, even if `pause` is still high; the next cycle then re-enters PAUSE.
- DONE:
  - `rem` holds 0.
  - `start` → RUN with `START_SEC`.
  - `bonus` and `tick_1s` are ignored.
- Arithmetic: `rem` + `BONUS_SEC` saturates at 99. Never wraps below 0 or above 99.
- Simultaneous events in RUN, in priority order:
  - `start` beats everything: load `START_SEC`; tick and bonus are discarded.
  - Tick and bonus together: `rem` = min(99, `rem` + `BONUS_SEC` − 1), with no transition to DONE. The exception is when the result is 0, which cannot occur since `BONUS_SEC` ≥ 1.
  - A bonus arriving on the same tick that would reach 0 rescues the round.
- `warn` = (RUN or PAUSE) and `rem` ≤ `WARN_SEC`.
- The first second after `start` is partial: the first tick after start decrements. There is no tick re-alignment.
- Reset mid-round: IDLE, `rem` = 0, and all outputs at their reset values on the next edge.

## Timing
- All outputs are registered and update on the clock edge after the sampled input cycle (latency 1).
- `timeout` is high for exactly one cycle, coincident with the first cycle that `done`=1 and digits show 00.
- Reset values:
  - `sec_tens`=0, `sec_ones`=0.
  - `running`=0, `paused`=0, `warn`=0, `done`=0, `timeout`=0.
- The BCD digits are registered alongside `rem`, so the digits and `rem` are never a cycle apart.
- Back-to-back `bonus` pulses on consecutive cycles each apply.

## Structure
- Shared package `game_pkg` holds:
  - the state typedef (IDLE, RUN, PAUSE, DONE);
  - `MAX_SEC` = 99;
  - the tick period constant 100 000 000, shared with the tick generator.
- One sub-module, `bin2bcd99`: combinational 7-bit (0..99) → two BCD digits. The parent registers its outputs.

## Test plan
- Reset, then `start` with defaults → digits 6/0 and `running`=1. After 50 ticks: 1/0 and `warn`=1. After 60 ticks total: 0/0, `done`=1, with a single-cycle `timeout`.
- `pause` held across 3 ticks at `rem`=42 → stays 42 and `paused`=1. Release, then one tick → 41.
- `bonus` at `rem`=97 → 99 (saturated). Tick and `bonus` in the same cycle at `rem`=20 → 24.
- Tick and `bonus` at `rem`=1 → `rem`=5, no `timeout`, still RUN.
- `start` in DONE and mid-RUN at `rem`=17, with a simultaneous tick → `rem`=60 next cycle. `rst` asserted mid-round → IDLE with all outputs 0 next cycle.
- Ticks and `bonus` in IDLE → digits remain 0/0, `running`=0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game timing blocks: round-timer states and
// the constants common to the tick generator and the countdown.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned MAX_SEC     = 99;
  localparam int unsigned TICK_PERIOD = 100_000_000;

endpackage

// File: rtl/bin2bcd99.sv
// Combinational 0..99 binary to two BCD digits; inputs above 99 show 99.
module bin2bcd99
  import game_pkg::*;
(
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [6:0] val;
  logic [6:0] q;
  logic [6:0] r;

  always_comb begin
    val  = (bin > 7'(MAX_SEC)) ? 7'(MAX_SEC) : bin;
    q    = val / 7'd10;
    r    = val % 7'd10;
    tens = q[3:0];
    ones = r[3:0];
  end

endmodule

// File: rtl/game_countdown.sv
// Round countdown timer: consumes the 1 s tick, supports pause, restart and
// saturating bonuses, and drives registered BCD digits plus status flags.
module game_countdown
  import game_pkg::*;
#(
  parameter int unsigned START_SEC = 60,
  parameter int unsigned BONUS_SEC = 5,
  parameter int unsigned WARN_SEC  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1s,
  input  logic       start,
  input  logic       pause,
  input  logic       bonus,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       paused,
  output logic       warn,
  output logic       done,
  output logic       timeout
);

  state_t     state_q, state_d;
  logic [6:0] rem_q, rem_d;
  logic [7:0] bonus_sum;
  logic [7:0] tick_bonus_sum;
  logic [6:0] rem_bonus;
  logic [6:0] rem_tick_bonus;
  logic [3:0] tens_d, ones_d;
  logic       warn_q, timeout_q;

  // Both sums are at most 198, so 8 bits never wrap before saturation.
  always_comb begin
    bonus_sum      = {1'b0, rem_q} + 8'(BONUS_SEC);
    tick_bonus_sum = bonus_sum - 8'd1;
    rem_bonus      = (bonus_sum > 8'(MAX_SEC)) ? 7'(MAX_SEC) : bonus_sum[6:0];
    rem_tick_bonus = (tick_bonus_sum > 8'(MAX_SEC)) ? 7'(MAX_SEC) : tick_bonus_sum[6:0];
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        rem_d = '0;
        if (start) begin
          state_d = RUN;
          rem_d   = 7'(START_SEC);
        end
      end
      RUN: begin
        if (start) begin
          rem_d = 7'(START_SEC);
        end else if (pause) begin
          // Pause wins over a coincident tick; a bonus still counts.
          state_d = PAUSE;
          if (bonus) rem_d = rem_bonus;
        end else if (tick_1s && bonus) begin
          rem_d = rem_tick_bonus;
        end else if (tick_1s) begin
          if (rem_q > 7'd1) begin
            rem_d = rem_q - 7'd1;
          end else begin
            rem_d   = '0;
            state_d = DONE;
          end
        end else if (bonus) begin
          rem_d = rem_bonus;
        end
      end
      PAUSE: begin
        if (start) begin
          state_d = RUN;
          rem_d   = 7'(START_SEC);
        end else begin
          if (!pause) state_d = RUN;
          if (bonus)  rem_d   = rem_bonus;
        end
      end
      DONE: begin
        rem_d = '0;
        if (start) begin
          state_d = RUN;
          rem_d   = 7'(START_SEC);
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end

  bin2bcd99 u_bcd (
    .bin  (rem_d),
    .tens (tens_d),
    .ones (ones_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      sec_tens  <= '0;
      sec_ones  <= '0;
      warn_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      sec_tens  <= tens_d;
      sec_ones  <= ones_d;
      warn_q    <= ((state_d == RUN) || (state_d == PAUSE)) && (rem_d <= 7'(WARN_SEC));
      timeout_q <= (state_d == DONE) && (state_q != DONE);
    end
  end

  assign running = (state_q == RUN);
  assign paused  = (state_q == PAUSE);
  assign done    = (state_q == DONE);
  assign warn    = warn_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_game_countdown.sv
// Directed self-checking bench for game_countdown with default parameters.
module tb_game_countdown;

  logic       clk = 1'b0;
  logic       rst, tick_1s, start, pause, bonus;
  logic [3:0] sec_tens, sec_ones;
  logic       running, paused, warn, done, timeout;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  game_countdown #(
    .START_SEC (60),
    .BONUS_SEC (5),
    .WARN_SEC  (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_1s  (tick_1s),
    .start    (start),
    .pause    (pause),
    .bonus    (bonus),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .running  (running),
    .paused   (paused),
    .warn     (warn),
    .done     (done),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic t, input logic s, input logic b);
    tick_1s = t; start = s; bonus = b;
    step();
    tick_1s = 1'b0; start = 1'b0; bonus = 1'b0;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      pulse(1'b1, 1'b0, 1'b0);
      step();
    end
  endtask

  // digits given as 8'hTO (tens/ones)
  task automatic status(input string tag, input logic [7:0] dig, input logic run,
                        input logic pau, input logic wrn, input logic dn, input logic to);
    check({tag, ".digits"},  {24'd0, sec_tens, sec_ones}, {24'd0, dig});
    check({tag, ".running"}, {31'd0, running}, {31'd0, run});
    check({tag, ".paused"},  {31'd0, paused},  {31'd0, pau});
    check({tag, ".warn"},    {31'd0, warn},    {31'd0, wrn});
    check({tag, ".done"},    {31'd0, done},    {31'd0, dn});
    check({tag, ".timeout"}, {31'd0, timeout}, {31'd0, to});
  endtask

  initial begin
    rst = 1'b1; tick_1s = 1'b0; start = 1'b0; pause = 1'b0; bonus = 1'b0;
    step(); step();
    status("reset", 8'h00, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // IDLE ignores tick, bonus and pause
    pause = 1'b1;
    pulse(1'b1, 1'b0, 1'b1);
    pause = 1'b0;
    status("idle_ignore", 8'h00, 0, 0, 0, 0, 0);

    pulse(1'b0, 1'b1, 1'b0);
    status("start", 8'h60, 1, 0, 0, 0, 0);
    ticks(49);
    status("t49", 8'h11, 1, 0, 0, 0, 0);
    ticks(1);
    status("t50", 8'h10, 1, 0, 1, 0, 0);
    ticks(9);
    status("t59", 8'h01, 1, 0, 1, 0, 0);
    pulse(1'b1, 1'b0, 1'b0);
    status("t60", 8'h00, 0, 0, 0, 1, 1);
    step();
    status("done_hold", 8'h00, 0, 0, 0, 1, 0);
    pulse(1'b1, 1'b0, 1'b1);
    status("done_ignore", 8'h00, 0, 0, 0, 1, 0);

    // restart from DONE, run down to 42, then pause across ticks
    pulse(1'b0, 1'b1, 1'b0);
    status("start_done", 8'h60, 1, 0, 0, 0, 0);
    ticks(18);
    status("at42", 8'h42, 1, 0, 0, 0, 0);
    pause = 1'b1;
    pulse(1'b1, 1'b0, 1'b0);
    status("pause_tick", 8'h42, 0, 1, 0, 0, 0);
    ticks(2);
    status("paused3", 8'h42, 0, 1, 0, 0, 0);
    pause = 1'b0;
    step();
    status("resume", 8'h42, 1, 0, 0, 0, 0);
    pulse(1'b1, 1'b0, 1'b0);
    status("resume_tick", 8'h41, 1, 0, 0, 0, 0);

    // bonus accepted while paused, restart while pause still high
    pause = 1'b1;
    pulse(1'b0, 1'b0, 1'b1);
    status("pause_bonus", 8'h46, 0, 1, 0, 0, 0);
    pulse(1'b0, 1'b1, 1'b0);
    status("pause_start", 8'h60, 1, 0, 0, 0, 0);
    step();
    status("repause", 8'h60, 0, 1, 0, 0, 0);
    pause = 1'b0;
    step();
    ticks(23);
    status("at37", 8'h37, 1, 0, 0, 0, 0);

    // 12 back-to-back bonuses 37->97, then saturate at 99
    bonus = 1'b1;
    for (int unsigned i = 0; i < 12; i++) step();
    bonus = 1'b0;
    status("at97", 8'h97, 1, 0, 0, 0, 0);
    pulse(1'b0, 1'b0, 1'b1);
    status("sat99", 8'h99, 1, 0, 0, 0, 0);
    pulse(1'b1, 1'b0, 1'b1);
    status("sat_tick_bonus", 8'h99, 1, 0, 0, 0, 0);

    ticks(79);
    status("at20", 8'h20, 1, 0, 0, 0, 0);
    pulse(1'b1, 1'b0, 1'b1);
    status("tick_bonus20", 8'h24, 1, 0, 0, 0, 0);
    ticks(23);
    status("at1", 8'h01, 1, 0, 1, 0, 0);
    pulse(1'b1, 1'b0, 1'b1);
    status("rescue", 8'h05, 1, 0, 1, 0, 0);

    // restart mid-run at 17 with a coincident tick
    pulse(1'b0, 1'b1, 1'b0);
    ticks(43);
    status("at17", 8'h17, 1, 0, 0, 0, 0);
    pulse(1'b1, 1'b1, 1'b1);
    status("start_tick", 8'h60, 1, 0, 0, 0, 0);

    ticks(55);
    status("at05", 8'h05, 1, 0, 1, 0, 0);
    rst = 1'b1;
    step();
    status("mid_reset", 8'h00, 0, 0, 0, 0, 0);
    rst = 1'b0;
    pulse(1'b1, 1'b0, 1'b1);
    status("idle_after_rst", 8'h00, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
